debounce_bank: RTL and testbench

Parametrised multi-channel debouncer for raw board inputs such as slide switches and push-buttons. It replaces the fixed 10-switch debouncer: channel count, filter length and synchroniser depth are parameters, and a per-channel input inversion mask handles active-low keys. Beyond the clean levels, it produces one-cycle rise/fall pulses, an any-change strobe and a long-press `held` flag. It sits between the FPGA pins and the game control FSMs, so consumers no longer need their own edge detectors.

---
 rtl/debounce_pkg.sv | 25 ++
 rtl/debounce_channel.sv | 138 +++++++++++++
 rtl/debounce_bank.sv | 59 +++++
 tb/tb_debounce_bank.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce_bank slice: channel FSM state,
// counter sizing and parameter legality.
package debounce_pkg;

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    OFF_2_ON = 2'd1,
    ON       = 2'd2,
    ON_2_OFF = 2'd3
  } db_state_e;

  // Width able to hold 0..max_val inclusive; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic bit params_ok(input int unsigned n_ch,
                                   input int unsigned debounce_cycles,
                                   input int unsigned sync_stages,
                                   input int unsigned hold_cycles);
    return (n_ch >= 1) && (debounce_cycles >= 1) &&
           (sync_stages >= 1) && (hold_cycles >= 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: optional inversion, synchroniser, OFF/ON FSM with
// confirmation counter, edge pulses and long-press hold counter.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter logic        INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic held
);

  localparam int unsigned CNT_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   held_q, held_d;
  logic                   s;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = raw ^ INVERT;
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      OFF: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ON;
            cnt_d   = '0;
          end else begin
            state_d = OFF_2_ON;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      OFF_2_ON: begin
        if (!s) begin
          state_d = OFF;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          state_d = ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ON: begin
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = OFF;
            cnt_d   = '0;
          end else begin
            state_d = ON_2_OFF;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ON_2_OFF: begin
        if (s) begin
          state_d = ON;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          state_d = OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Hold count follows the registered level; held uses the next level so it
  // drops on the same edge clean falls.
  always_comb begin
    clean_d = (state_d == ON) || (state_d == ON_2_OFF);
    rise_d  = clean_d & ~clean_q;
    fall_d  = ~clean_d & clean_q;
    hold_d  = '0;
    if (clean_q) begin
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
    end
    held_d  = clean_d && (hold_d == HOLD_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= OFF;
      cnt_q   <= '0;
      hold_q  <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      held_q  <= held_d;
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign held  = held_q;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: N_CH independent lanes plus a registered
// any-change strobe covering every rise/fall of the previous cycle.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned     N_CH            = 10,
  parameter int unsigned     DEBOUNCE_CYCLES = 1000,
  parameter int unsigned     SYNC_STAGES     = 2,
  parameter int unsigned     HOLD_CYCLES     = 50_000_000,
  parameter logic [N_CH-1:0] INVERT_MASK     = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw,
  output logic [N_CH-1:0] clean,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] held,
  output logic            any_change
);

  if (!params_ok(N_CH, DEBOUNCE_CYCLES, SYNC_STAGES, HOLD_CYCLES)) begin : g_param_err
    $error("debounce_bank: N_CH, DEBOUNCE_CYCLES, SYNC_STAGES and HOLD_CYCLES must all be >= 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .INVERT          (INVERT_MASK[i])
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[i]),
      .clean (clean[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .held  (held[i])
    );
  end

  logic any_change_q, any_change_d;

  always_comb begin
    any_change_d = |(rise | fall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_change_q <= 1'b0;
    end else begin
      any_change_q <= any_change_d;
    end
  end

  assign any_change = any_change_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: stimulus queues expected output events
// with their edge numbers; a monitor pops one whenever the DUT shows activity.
module tb_debounce_bank;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] raw   = 4'b1000;
  logic [3:0] clean, rise, fall, held;
  logic       any_change;

  typedef struct {
    int         at;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] held;
    logic [3:0] clean;
    logic       any;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [3:0] held_prev = '0;

  debounce_bank #(
    .N_CH            (4),
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2),
    .HOLD_CYCLES     (8),
    .INVERT_MASK     (4'b1000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (raw),
    .clean      (clean),
    .rise       (rise),
    .fall       (fall),
    .held       (held),
    .any_change (any_change)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int at, input logic [3:0] r, input logic [3:0] f,
                           input logic [3:0] h, input logic [3:0] c, input logic a);
    ev_t e;
    e.at = at; e.rise = r; e.fall = f; e.held = h; e.clean = c; e.any = a;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk4({tag, "_clean"}, clean, 4'b0000);
    chk4({tag, "_rise"},  rise,  4'b0000);
    chk4({tag, "_fall"},  fall,  4'b0000);
    chk4({tag, "_held"},  held,  4'b0000);
    chk1({tag, "_any"},   any_change, 1'b0);
  endtask

  // Monitor: any pulse or held transition is an output event to be matched.
  always @(negedge clk) begin
    if (rst_n && (rise != 4'b0 || fall != 4'b0 || any_change || held != held_prev)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got rise=%b fall=%b held=%b any=%b expected none (edge %0d)",
                 rise, fall, held, any_change, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk_int("ev_edge", cyc, mon_e.at);
        chk4("ev_rise",  rise,  mon_e.rise);
        chk4("ev_fall",  fall,  mon_e.fall);
        chk4("ev_held",  held,  mon_e.held);
        chk4("ev_clean", clean, mon_e.clean);
        chk1("ev_any",   any_change, mon_e.any);
      end
    end
    held_prev = held;
  end

  initial begin
    int k;

    // Reset with inverted ch3 released: everything reads 0, no pulses after release.
    step(2);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(10);

    // ch0 rise, any_change one later, held after 8 edges.
    k = cyc; raw[0] = 1'b1;
    expect_ev(k + 6,  4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    expect_ev(k + 7,  4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    expect_ev(k + 14, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0);
    step(16);

    // ch0 release: fall and held drop on the same edge.
    k = cyc; raw[0] = 1'b0;
    expect_ev(k + 6, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    expect_ev(k + 7, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step(8);

    // ch1 3-sample glitch is swallowed, then a steady high qualifies.
    raw[1] = 1'b1;
    step(3);
    raw[1] = 1'b0;
    step(4);
    k = cyc; raw[1] = 1'b1;
    expect_ev(k + 6,  4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    expect_ev(k + 7,  4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b1);
    expect_ev(k + 14, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 1'b0);
    step(16);
    k = cyc; raw[1] = 1'b0;
    expect_ev(k + 6, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    expect_ev(k + 7, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step(8);

    // ch0 on again, then ch0 off / ch2 on together: coincident pulses, one any_change.
    k = cyc; raw[0] = 1'b1;
    expect_ev(k + 6,  4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    expect_ev(k + 7,  4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    expect_ev(k + 14, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0);
    step(16);
    k = cyc; raw[0] = 1'b0; raw[2] = 1'b1;
    expect_ev(k + 6, 4'b0100, 4'b0001, 4'b0000, 4'b0100, 1'b0);
    expect_ev(k + 7, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b1);
    step(8);

    // ch2 falls on the edge its hold would have completed: held never asserts.
    k = cyc; raw[2] = 1'b0;
    expect_ev(k + 6, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    expect_ev(k + 7, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step(8);

    // Reset while ch2 is at cnt=2: clears at once, full count needed afterwards.
    raw[2] = 1'b1;
    step(4);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    step(3);
    k = cyc; rst_n = 1'b1;
    expect_ev(k + 6,  4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    expect_ev(k + 7,  4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b1);
    expect_ev(k + 14, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1'b0);
    step(16);

    @(posedge clk);
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event: got nothing expected event at edge %0d (rise=%b fall=%b held=%b any=%b)",
               mon_e.at, mon_e.rise, mon_e.fall, mon_e.held, mon_e.any);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
